// File: rtl/sonar_ranger.sv
// Ultrasonic ranging controller: fires a trigger pulse and measures the echo high time in clocks.
// Optional macro SONAR_ECHO_SYNC_EN adds a two-flop synchroniser on echo_in.
module sonar_ranger #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 3_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        echo_in,
  output logic        trig_out,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] echo_width
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_e;

  localparam logic [31:0] TRIG_C    = 32'(TRIG_CYCLES);
  localparam logic [31:0] TO_C      = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HOLD_C    = 32'(HOLDOFF_CYCLES);
  localparam logic [31:0] WIDTH_MAX = 32'hFFFF_FFFE;
  localparam logic [31:0] TO_CODE   = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] echo_width_q, echo_width_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cnt_inc, tcnt_inc;
  logic        echo_s;

`ifdef SONAR_ECHO_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = echo_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign echo_s = sync2_q;
`else
  assign echo_s = echo_in;
`endif

  assign cnt_inc  = cnt_q + 32'd1;
  assign tcnt_inc = tcnt_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    echo_width_d = echo_width_q;
    timeout_d    = timeout_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_inc >= TRIG_C) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_RISE: begin
        tcnt_d = tcnt_inc;
        if (tcnt_inc >= TO_C) begin
          state_d      = HOLDOFF;
          cnt_d        = '0;
          echo_width_d = TO_CODE;
          timeout_d    = 1'b1;
          done_d       = 1'b1;
        end else if (echo_s) begin
          state_d = MEASURE;
          cnt_d   = 32'd1;
        end
      end
      MEASURE: begin
        tcnt_d = tcnt_inc;
        // A falling echo beats a timeout landing on the same sample.
        if (!echo_s) begin
          state_d      = HOLDOFF;
          cnt_d        = '0;
          echo_width_d = cnt_q;
          timeout_d    = 1'b0;
          done_d       = 1'b1;
        end else if (tcnt_inc >= TO_C) begin
          state_d      = HOLDOFF;
          cnt_d        = '0;
          echo_width_d = TO_CODE;
          timeout_d    = 1'b1;
          done_d       = 1'b1;
        end else if (cnt_q != WIDTH_MAX) begin
          cnt_d = cnt_inc;
        end
      end
      HOLDOFF: begin
        if (cnt_inc >= HOLD_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      echo_width_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      echo_width_q <= echo_width_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign trig_out   = (state_q == TRIG);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign echo_width = echo_width_q;

endmodule

// File: doc/sonar_ranger.md
# sonar_ranger

Ultrasonic ranging controller sitting directly downstream of the GPIO pin set: it drives the sensor trigger pin and consumes the synchronised echo pin value, converting the echo pulse into a 32-bit clock-cycle count for the processor. One measurement per `start` pulse. Results are held in an output register until the next measurement begins. A timeout flag reports a missing or stuck echo.

## Interface
- `TRIG_CYCLES`, default 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 2_000_000: maximum clocks from trigger fall to echo fall.
- `HOLDOFF_CYCLES`, default 3_000_000: recovery gap after a result, before the next trigger is allowed.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request a measurement; sampled only in IDLE.
- `echo_in`  in  1  echo pin level from the GPIO pin-set `out` bit.
- `trig_out`  out  1  trigger level to the GPIO pin value input.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `echo_width` and `timeout` are updated.
- `timeout`  out  1  last measurement timed out; held until the next `done`.
- `echo_width`  out  32  echo high time in clocks; `32'hFFFF_FFFF` on timeout.

## Operation
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: `busy`=0. If `start`=1, go to TRIG and clear the cycle counter. `start` in any other state is ignored, with no queuing.
- TRIG: `trig_out`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE. Clear the counter and the timeout counter.
- WAIT_RISE: the timeout counter increments each cycle. The first cycle with `echo_s`=1 moves to MEASURE, and that cycle counts as width 1. An echo already high on entry counts as a rise.
- MEASURE: the width counter increments each cycle `echo_s`=1. The first cycle with `echo_s`=0 ends the measurement:
  - `echo_width`←counter.
  - `timeout`←0.
  - `done` pulses.
  - Go to HOLDOFF.
- Timeout: the timeout counter runs across WAIT_RISE and MEASURE. When it reaches `TIMEOUT_CYCLES`:
  - `echo_width`←`32'hFFFF_FFFF`.
  - `timeout`←1.
  - `done` pulses.
  - Go to HOLDOFF.
- If an echo fall and the timeout occur in the same cycle, the echo fall wins.
- Width counter saturates at `32'hFFFF_FFFE`, so it never aliases the timeout code.
- HOLDOFF: wait `HOLDOFF_CYCLES` cycles, then return to IDLE. `busy` stays 1.
- `echo_s` is the echo as seen by the FSM (see Configuration).

## Timing
- Reset (`reset`=0 at an edge) gives:
  - state=IDLE;
  - `trig_out`=0, `busy`=0, `done`=0, `timeout`=0;
  - `echo_width`=0;
  - all counters=0.
- Reset mid-operation aborts with no `done` pulse, and `trig_out` drops at that edge.
- `start` high at edge N: `busy` and `trig_out` go high after edge N. `trig_out` falls after edge N+`TRIG_CYCLES`.
- `done`, `echo_width` and `timeout` update together, registered one edge after the deciding `echo_s` sample.
- `done` is high for exactly one cycle. `echo_width` and `timeout` hold until the next `done` or reset.
- The synchroniser delay shifts both echo edges equally, so the width value is unaffected.

## Configuration
- `SONAR_ECHO_SYNC_EN` defined: `echo_in` passes through a two-flop synchroniser, reset to 0. `echo_s` lags `echo_in` by 2 cycles, which adds 2 cycles to the echo-fall→`done` latency.
- Not defined: `echo_s` = `echo_in` directly, with no added latency. This build is for benches and for callers that already synchronise the echo.

## Test plan
Bench parameters for all scenarios: `TRIG_CYCLES`=4, `TIMEOUT_CYCLES`=64, `HOLDOFF_CYCLES`=8. Run each scenario with and without the macro.
- Nominal: `start` pulse; echo high for 20 cycles, rising 3 cycles after trigger fall → `trig_out` high exactly 4 cycles; `done` once; `echo_width`=20; `timeout`=0; `busy` low 8 cycles after `done`.
- No echo: `start`; echo held low → `done` 64 cycles after trigger fall; `echo_width`=`FFFF_FFFF`; `timeout`=1.
- Stuck echo: echo rises, never falls → timeout result as above at cycle 64; the next nominal run clears `timeout` to 0.
- Busy/holdoff: `start` pulsed during MEASURE and during HOLDOFF → no extra trigger; exactly one `done`.
- Minimum pulse: echo high for 1 cycle → `echo_width`=1.
- Reset mid-MEASURE: `reset`=0 for one edge → all outputs 0 next cycle; no `done`; a new `start` measures correctly.
